// File: rtl/game_pkg.sv
// game_pkg: shared command/state encodings, board geometry and box-origin helper
package game_pkg;
    localparam int CELL_W = 5;
    localparam int MAX_SIDE = 16;
    typedef enum logic [2:0] {CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_SET, CMD_CLEAR, CMD_NEW} cmd_t;
    typedef enum logic [1:0] {IDLE, CHECK, WIPE} state_t;
    // (pos / s) * s for the three legal box sides, without a divider
    function automatic logic [3:0] box_base(input logic [3:0] pos, input logic [2:0] s);
        case (s)
            3'd2: box_base = {pos[3:1], 1'b0};
            3'd3: box_base = pos < 4'd3 ? 4'd0 : pos < 4'd6 ? 4'd3 : pos < 4'd9 ? 4'd6 : 4'd9;
            default: box_base = {pos[3:2], 2'b00};
        endcase
    endfunction
endpackage

// File: rtl/board_rule_checker.sv
// board_rule_checker: per-step row/column/box duplicate compare with a sticky conflict flag
module board_rule_checker
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    input  logic [3:0] k,
    input  logic [CELL_W-1:0] digit,
    input  logic [3:0] cx,
    input  logic [3:0] cy,
    input  logic [2:0] s,
    input  logic [MAX_SIDE-1:0][MAX_SIDE-1:0][CELL_W-1:0] board,
    output logic conflict
);
    logic [3:0] by, bx, kbase, kdiv, br, bc;
    logic hit, sticky;
    assign by = box_base(cy, s);
    assign bx = box_base(cx, s);
    assign kbase = box_base(k, s);
    // k / s reuses the box origin of k for the odd side
    assign kdiv = s == 3'd2 ? k >> 1 : s == 3'd3 ? (kbase == 4'd0 ? 4'd0 : kbase == 4'd3 ? 4'd1 : 4'd2) : k >> 2;
    assign br = by + kdiv;
    assign bc = bx + (k - kbase);
    assign hit = (k != cx && board[cy][k] == digit) ||
                 (k != cy && board[k][cx] == digit) ||
                 (!(br == cy && bc == cx) && board[br][bc] == digit);
    assign conflict = sticky | (en & hit);
    always_ff @(posedge clk)
        if (rst || start) sticky <= 1'b0;
        else if (en && hit) sticky <= 1'b1;
endmodule

// File: rtl/board_edit_ctrl.sv
// board_edit_ctrl: board register array, cursor and command sequencing (move/set/clear/new)
module board_edit_ctrl
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic is_game_on,
    input  logic [2:0] board_size,
    input  logic cmd_valid,
    input  logic [2:0] cmd,
    input  logic [4:0] cmd_digit,
    output logic cmd_ready,
    output logic [MAX_SIDE-1:0][MAX_SIDE-1:0][CELL_W-1:0] board,
    output logic [2:0] size_q,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic set_ok,
    output logic set_err,
    output logic solved
);
    state_t state, state_d;
    cmd_t c;
    logic [3:0] k, cx_q, cy_q, n_m1;
    logic [4:0] dig_q, n;
    logic [8:0] filled, filled_d, n_sq;
    logic [2:0] s_new;
    logic live, set_go, set_bad, new_go, clr_go, chk_done, wr_ok, conflict;
    assign c = cmd_t'(cmd);
    assign n = {2'd0, size_q} * {2'd0, size_q};
    assign n_m1 = n[3:0] - 4'd1;
    assign n_sq = {4'd0, n} * {4'd0, n};
    assign s_new = board_size < 3'd2 ? 3'd2 : board_size > 3'd4 ? 3'd4 : board_size;
    assign cmd_ready = state == IDLE;
    // with the game off, everything but NEW is swallowed without effect
    assign live = cmd_valid && cmd_ready && (is_game_on || c == CMD_NEW);
    assign set_go = live && c == CMD_SET && cmd_digit != 5'd0 && cmd_digit <= n;
    assign set_bad = live && c == CMD_SET && (cmd_digit == 5'd0 || cmd_digit > n);
    assign new_go = live && c == CMD_NEW;
    assign clr_go = live && c == CMD_CLEAR && board[cursor_y][cursor_x] != '0;
    assign chk_done = state == CHECK && k == n_m1;
    assign wr_ok = chk_done && !conflict;
    board_rule_checker u_chk (
        .clk(clk), .rst(rst), .start(set_go), .en(state == CHECK), .k(k), .digit(dig_q),
        .cx(cx_q), .cy(cy_q), .s(size_q), .board(board), .conflict(conflict)
    );
    always_comb begin
        state_d = state == IDLE ? (set_go ? CHECK : new_go ? WIPE : IDLE) :
                  state == CHECK ? (chk_done ? IDLE : CHECK) : (k == 4'd15 ? IDLE : WIPE);
        filled_d = new_go ? 9'd0 :
                   clr_go ? (filled == 9'd0 ? 9'd0 : filled - 9'd1) :
                   (wr_ok && board[cy_q][cx_q] == '0 && filled != 9'd256) ? filled + 9'd1 : filled;
    end
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            board <= '0;
            size_q <= 3'd3;
            cursor_x <= '0;
            cursor_y <= '0;
            filled <= '0;
            set_ok <= 1'b0;
            set_err <= 1'b0;
            solved <= 1'b0;
            dig_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            k <= state == IDLE ? 4'd0 : k + 4'd1;
            filled <= filled_d;
            solved <= is_game_on && filled_d == n_sq;
            set_ok <= wr_ok;
            set_err <= set_bad || (chk_done && conflict);
            if (set_go) begin
                dig_q <= cmd_digit;
                cx_q <= cursor_x;
                cy_q <= cursor_y;
            end
            if (live && c == CMD_UP) cursor_y <= cursor_y == 4'd0 ? n_m1 : cursor_y - 4'd1;
            if (live && c == CMD_DOWN) cursor_y <= cursor_y == n_m1 ? 4'd0 : cursor_y + 4'd1;
            if (live && c == CMD_LEFT) cursor_x <= cursor_x == 4'd0 ? n_m1 : cursor_x - 4'd1;
            if (live && c == CMD_RIGHT) cursor_x <= cursor_x == n_m1 ? 4'd0 : cursor_x + 4'd1;
            if (clr_go) board[cursor_y][cursor_x] <= '0;
            if (wr_ok) board[cy_q][cx_q] <= dig_q;
            if (state == WIPE) board[k] <= '0;
            if (new_go) begin
                size_q <= s_new;
                cursor_x <= '0;
                cursor_y <= '0;
            end
        end
    end
endmodule

// File: tb/tb_board_edit_ctrl.sv
// tb_board_edit_ctrl: directed + random commands scored against a cell-level board model
module tb_board_edit_ctrl;
    import game_pkg::*;
    logic clk = 1'b0, rst = 1'b1, is_game_on = 1'b1, cmd_valid = 1'b0;
    logic [2:0] board_size = 3'd3, cmd = 3'd0, size_q;
    logic [4:0] cmd_digit = 5'd0;
    logic cmd_ready, set_ok, set_err, solved;
    logic [MAX_SIDE-1:0][MAX_SIDE-1:0][CELL_W-1:0] board;
    logic [3:0] cursor_x, cursor_y;
    int vectors = 0, miscompares = 0;
    int mb[16][16];
    int ms, mcx, mcy;

    board_edit_ctrl dut (
        .clk(clk), .rst(rst), .is_game_on(is_game_on), .board_size(board_size),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_digit(cmd_digit), .cmd_ready(cmd_ready),
        .board(board), .size_q(size_q), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .set_ok(set_ok), .set_err(set_err), .solved(solved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int filled_cells();
        int f = 0;
        for (int r = 0; r < 16; r++)
            for (int q = 0; q < 16; q++)
                if (mb[r][q] != 0) f++;
        return f;
    endfunction

    function automatic bit conflicts(input int r, input int q, input int d);
        for (int i = 0; i < ms * ms; i++) begin
            int br, bc;
            br = (r / ms) * ms + i / ms;
            bc = (q / ms) * ms + i % ms;
            if (i != q && mb[r][i] == d) return 1'b1;
            if (i != r && mb[i][q] == d) return 1'b1;
            if (!(br == r && bc == q) && mb[br][bc] == d) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++)
            for (int q = 0; q < 16; q++) mb[r][q] = 0;
        ms = 3;
        mcx = 0;
        mcy = 0;
    endtask

    task automatic check_state(input string tag);
        int n = ms * ms;
        check({tag, "_cx"}, 80'(cursor_x), 80'(mcx));
        check({tag, "_cy"}, 80'(cursor_y), 80'(mcy));
        check({tag, "_size"}, 80'(size_q), 80'(ms));
        check({tag, "_ready"}, 80'(cmd_ready), 80'(1));
        check({tag, "_pulse"}, 80'({set_ok, set_err}), 80'(0));
        check({tag, "_solved"}, 80'(solved), 80'(is_game_on && filled_cells() == n * n));
        for (int r = 0; r < 16; r++) begin
            logic [79:0] e;
            for (int q = 0; q < 16; q++) e[q*5 +: 5] = 5'(mb[r][q]);
            check($sformatf("%s_row%0d", tag, r), board[r], e);
        end
    endtask

    // busy-time noise: must be ignored by the DUT
    task automatic garbage(input bit on);
        cmd_valid = on ? 1'($urandom % 2) : 1'b0;
        cmd = 3'($urandom % 7);
        cmd_digit = 5'($urandom % 17);
    endtask

    task automatic issue(input cmd_t c, input int d, input int bs);
        int n, lat, busy;
        bit live, exp_err, ok, er;
        n = ms * ms;
        live = is_game_on || c == CMD_NEW;
        ok = 1'b0;
        er = 1'b0;
        check("ready_pre", 80'(cmd_ready), 80'(1));
        cmd_valid = 1'b1;
        cmd = c;
        cmd_digit = 5'(d);
        board_size = 3'(bs);
        step();
        cmd_valid = 1'b0;
        if (!live) begin
            check_state("gated");
            return;
        end
        case (c)
            CMD_UP: mcy = mcy == 0 ? n - 1 : mcy - 1;
            CMD_DOWN: mcy = mcy == n - 1 ? 0 : mcy + 1;
            CMD_LEFT: mcx = mcx == 0 ? n - 1 : mcx - 1;
            CMD_RIGHT: mcx = mcx == n - 1 ? 0 : mcx + 1;
            CMD_CLEAR: mb[mcy][mcx] = 0;
            CMD_SET:
                if (d < 1 || d > n) begin
                    check("ill_err", 80'(set_err), 80'(1));
                    check("ill_ok", 80'(set_ok), 80'(0));
                    check("ill_ready", 80'(cmd_ready), 80'(1));
                    step();
                end else begin
                    exp_err = conflicts(mcy, mcx, d);
                    lat = -1;
                    busy = 0;
                    for (int i = 0; i < n + 2; i++) begin
                        if (i > 0) step();
                        if (!cmd_ready) busy++;
                        if ((set_ok || set_err) && lat < 0) begin
                            lat = i;
                            ok = set_ok;
                            er = set_err;
                        end
                        garbage(i < n);
                    end
                    check("set_lat", 80'(lat), 80'(n));
                    check("set_busy", 80'(busy), 80'(n));
                    check("set_ok", 80'(ok), 80'(!exp_err));
                    check("set_err", 80'(er), 80'(exp_err));
                    if (!exp_err) mb[mcy][mcx] = d;
                end
            CMD_NEW: begin
                ms = bs < 2 ? 2 : bs > 4 ? 4 : bs;
                mcx = 0;
                mcy = 0;
                for (int r = 0; r < 16; r++)
                    for (int q = 0; q < 16; q++) mb[r][q] = 0;
                check("new_solved", 80'(solved), 80'(0));
                busy = 0;
                for (int i = 0; i < 20; i++) begin
                    if (i > 0) step();
                    if (!cmd_ready) busy++;
                    garbage(i < 16);
                end
                check("wipe_busy", 80'(busy), 80'(16));
            end
            default: ;
        endcase
        check_state("cmd");
    endtask

    task automatic goto_cell(input int x, input int y);
        while (mcx != x) issue(CMD_RIGHT, 0, 3);
        while (mcy != y) issue(CMD_DOWN, 0, 3);
    endtask

    task automatic set_game(input bit v);
        is_game_on = v;
        step();
        check_state("game");
    endtask

    task automatic count_pulses(input string tag);
        int p = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (set_ok || set_err) p++;
        end
        check(tag, 80'(p), 80'(0));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_state("reset");
        issue(CMD_NEW, 0, 3);
        issue(CMD_LEFT, 0, 3);
        check("t2_left", 80'(cursor_x), 80'(8));
        issue(CMD_UP, 0, 3);
        check("t2_up", 80'(cursor_y), 80'(8));
        issue(CMD_RIGHT, 0, 3);
        check("t2_right", 80'(cursor_x), 80'(0));
        issue(CMD_DOWN, 0, 3);
        issue(CMD_SET, 5, 3);
        check("t3_cell", 80'(board[0][0]), 80'(5));
        goto_cell(4, 0);
        issue(CMD_SET, 5, 3);
        check("t3_keep", 80'(board[0][4]), 80'(0));
        goto_cell(1, 1);
        issue(CMD_SET, 5, 3);
        goto_cell(3, 3);
        issue(CMD_SET, 5, 3);
        issue(CMD_SET, 10, 3);
        issue(CMD_NEW, 0, 2);
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) begin
                goto_cell(q, r);
                issue(CMD_SET, ((2 * (r % 2) + r / 2 + q) % 4) + 1, 3);
            end
        check("t5_solved", 80'(solved), 80'(1));
        goto_cell(2, 2);
        issue(CMD_CLEAR, 0, 3);
        check("t5_unsolved", 80'(solved), 80'(0));
        issue(CMD_NEW, 0, 3);
        goto_cell(4, 4);
        cmd_valid = 1'b1;
        cmd = CMD_SET;
        cmd_digit = 5'd7;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_state("rst_mid");
        count_pulses("rst_nopulse");
        set_game(1'b0);
        issue(CMD_SET, 1, 3);
        count_pulses("gated_nopulse");
        set_game(1'b1);
        issue(CMD_NEW, 0, 0);
        check("clamp_lo", 80'(size_q), 80'(2));
        issue(CMD_NEW, 0, 7);
        check("clamp_hi", 80'(size_q), 80'(4));
        repeat (400) begin
            int r, n;
            r = $urandom % 16;
            n = ms * ms;
            if (r < 6) issue(cmd_t'(r % 4), 0, 3);
            else if (r < 11) issue(CMD_SET, 1 + $urandom % n, 3);
            else if (r < 13) issue(CMD_CLEAR, 0, 3);
            else if (r == 13) issue(CMD_NEW, 0, $urandom % 8);
            else if (r == 14) set_game(($urandom % 4) != 0);
            else issue(CMD_SET, ($urandom % 2) ? 0 : n + 1 + $urandom % (17 - n), 3);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
